// File: rtl/cgra_cfg_pkg.sv
// Shared constants and FSM state type for the PE configuration loader.
// The CHECK state exists only when CGRA_CFG_CHECKSUM_EN is defined.
package cgra_cfg_pkg;
   localparam int CFG_WIDTH     = 96;
   localparam int BS_WIDTH_DFLT = 32;
   localparam int WORDS_PER_PE  = 3;

`ifdef CGRA_CFG_CHECKSUM_EN
   typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_COMMIT, ST_CHECK, ST_DONE} state_e;
`else
   typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_COMMIT, ST_DONE} state_e;
`endif
endpackage

// File: rtl/pe_config_loader.sv
// Streams 3-word configurations onto a shared bus and strobes each PE in turn.
// Optional trailing XOR checksum word when CGRA_CFG_CHECKSUM_EN is defined.
module pe_config_loader
   import cgra_cfg_pkg::*;
#(
   parameter int NUM_PE   = 16,
   parameter int BS_WIDTH = BS_WIDTH_DFLT
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  abort,
   input  logic [BS_WIDTH-1:0]   bs_data,
   input  logic                  bs_v,
   output logic                  bs_r,
   output logic [CFG_WIDTH-1:0]  config_bits,
   output logic [NUM_PE-1:0]     catch_config,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   localparam int                 IDX_W    = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
   localparam logic [IDX_W-1:0]   LAST_PE  = IDX_W'(NUM_PE - 1);
   localparam logic [1:0]         LAST_WRD = 2'(WORDS_PER_PE - 1);

   state_e                 state_q;
   logic [IDX_W-1:0]       pe_idx_q;
   logic [1:0]             word_cnt_q;
   logic [CFG_WIDTH-1:0]   cfg_q;
   logic [NUM_PE-1:0]      catch_q;
   logic                   bs_r_q;
   logic                   busy_q;
   logic                   done_q;
   logic                   accept_d;

   assign accept_d     = bs_v && bs_r_q;
   assign bs_r         = bs_r_q;
   assign config_bits  = cfg_q;
   assign catch_config = catch_q;
   assign busy         = busy_q;
   assign done         = done_q;

`ifdef CGRA_CFG_CHECKSUM_EN
   logic [BS_WIDTH-1:0] acc_q;
   logic                err_q;
   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   // Outputs are registered alongside the state they belong to, so every
   // transition below also sets the output values of the state it enters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         pe_idx_q   <= '0;
         word_cnt_q <= '0;
         cfg_q      <= '0;
         catch_q    <= '0;
         bs_r_q     <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
`ifdef CGRA_CFG_CHECKSUM_EN
         acc_q      <= '0;
         err_q      <= 1'b0;
`endif
      end else begin
         done_q  <= 1'b0;
         catch_q <= '0;
         if (abort && (state_q != ST_IDLE)) begin
            state_q <= ST_IDLE;
            bs_r_q  <= 1'b0;
            busy_q  <= 1'b0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (start && !abort) begin
                     state_q    <= ST_LOAD;
                     pe_idx_q   <= '0;
                     word_cnt_q <= '0;
                     bs_r_q     <= 1'b1;
                     busy_q     <= 1'b1;
`ifdef CGRA_CFG_CHECKSUM_EN
                     acc_q      <= '0;
                     err_q      <= 1'b0;
`endif
                  end
               end
               ST_LOAD: begin
                  if (accept_d) begin
                     cfg_q[word_cnt_q*BS_WIDTH +: BS_WIDTH] <= bs_data;
`ifdef CGRA_CFG_CHECKSUM_EN
                     acc_q <= acc_q ^ bs_data;
`endif
                     if (word_cnt_q == LAST_WRD) begin
                        word_cnt_q <= '0;
                        state_q    <= ST_COMMIT;
                        bs_r_q     <= 1'b0;
                        catch_q    <= NUM_PE'(1) << pe_idx_q;
                     end else begin
                        word_cnt_q <= word_cnt_q + 2'd1;
                     end
                  end
               end
               ST_COMMIT: begin
                  if (pe_idx_q == LAST_PE) begin
`ifdef CGRA_CFG_CHECKSUM_EN
                     state_q <= ST_CHECK;
                     bs_r_q  <= 1'b1;
`else
                     state_q <= ST_DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
`endif
                  end else begin
                     pe_idx_q <= pe_idx_q + 1'b1;
                     state_q  <= ST_LOAD;
                     bs_r_q   <= 1'b1;
                  end
               end
`ifdef CGRA_CFG_CHECKSUM_EN
               ST_CHECK: begin
                  if (accept_d) begin
                     if (bs_data != acc_q) err_q <= 1'b1;
                     state_q <= ST_DONE;
                     bs_r_q  <= 1'b0;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end
               end
`endif
               ST_DONE: state_q <= ST_IDLE;
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pe_config_loader.sv
// Directed bench for pe_config_loader with NUM_PE=2; checksum steps follow CGRA_CFG_CHECKSUM_EN.
`timescale 1ns/1ps
module tb_pe_config_loader;
   localparam int NUM_PE = 2;
   localparam int BS_W   = 32;

   logic              clk     = 1'b0;
   logic              rst_n   = 1'b1;
   logic              start   = 1'b0;
   logic              abort   = 1'b0;
   logic              bs_v    = 1'b0;
   logic [BS_W-1:0]   bs_data = '0;
   logic              bs_r;
   logic [95:0]       config_bits;
   logic [NUM_PE-1:0] catch_config;
   logic              busy;
   logic              done;
   logic              err;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   pe_config_loader #(.NUM_PE(NUM_PE), .BS_WIDTH(BS_W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .abort        (abort),
      .bs_data      (bs_data),
      .bs_v         (bs_v),
      .bs_r         (bs_r),
      .config_bits  (config_bits),
      .catch_config (catch_config),
      .busy         (busy),
      .done         (done),
      .err          (err)
   );

   task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_start;
      start = 1'b1;
      bs_v  = 1'b1;
      tick;
      start = 1'b0;
      chk1("start_busy", busy, 1'b1);
      chk1("start_bs_r", bs_r, 1'b1);
   endtask

   task automatic feed(input logic [31:0] w, input bit stall);
      if (stall) begin
         bs_v    = 1'b0;
         bs_data = 32'hBAD0_BAD0;
         tick;
         chk1("stall_bs_r", bs_r, 1'b1);
         chk("stall_catch", 96'(catch_config), 96'(0));
      end
      bs_v    = 1'b1;
      bs_data = w;
      tick;
   endtask

   task automatic load_pe(input int pe, input logic [31:0] w0, input logic [31:0] w1,
                          input logic [31:0] w2, input bit stall);
      logic [NUM_PE-1:0] oh;
      oh     = '0;
      oh[pe] = 1'b1;
      feed(w0, stall);
      chk("mid_catch", 96'(catch_config), 96'(0));
      feed(w1, stall);
      feed(w2, stall);
      chk("commit_catch", 96'(catch_config), 96'(oh));
      chk("commit_cfg", config_bits, {w2, w1, w0});
      chk1("commit_busy", busy, 1'b1);
      chk1("commit_bs_r", bs_r, 1'b0);
      chk1("commit_done", done, 1'b0);
      bs_v    = 1'b1;
      bs_data = 32'hDEAD_BEEF;
      tick;
      chk("post_commit_catch", 96'(catch_config), 96'(0));
      chk("post_commit_cfg", config_bits, {w2, w1, w0});
   endtask

   task automatic finish_load(input logic [31:0] csum, input logic exp_err);
`ifdef CGRA_CFG_CHECKSUM_EN
      chk1("check_bs_r", bs_r, 1'b1);
      chk1("check_busy", busy, 1'b1);
      chk1("check_done", done, 1'b0);
      bs_v    = 1'b1;
      bs_data = csum;
      tick;
`endif
      chk1("done_pulse", done, 1'b1);
      chk1("done_busy", busy, 1'b0);
      chk1("done_bs_r", bs_r, 1'b0);
      chk1("done_err", err, exp_err);
      bs_v = 1'b1;
      tick;
      chk1("idle_done", done, 1'b0);
      chk1("idle_busy", busy, 1'b0);
      chk1("err_hold", err, exp_err);
   endtask

   initial begin
      // reset state
      #1 rst_n = 1'b0;
      #1;
      chk("rst_cfg", config_bits, 96'(0));
      chk("rst_catch", 96'(catch_config), 96'(0));
      chk1("rst_bs_r", bs_r, 1'b0);
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_done", done, 1'b0);
      chk1("rst_err", err, 1'b0);
      tick;
      rst_n = 1'b1;
      tick;

      // back-to-back load, bs_v held high
      do_start;
      load_pe(0, 32'h1, 32'h2, 32'h3, 1'b0);
      chk1("pe1_load_bs_r", bs_r, 1'b1);
      load_pe(1, 32'h4, 32'h5, 32'h6, 1'b0);
      finish_load(32'h7, 1'b0);

      // same load with bs_v toggling
      do_start;
      load_pe(0, 32'h1, 32'h2, 32'h3, 1'b1);
      load_pe(1, 32'h4, 32'h5, 32'h6, 1'b1);
      finish_load(32'h7, 1'b0);

      // abort on the second handshake of PE1
      do_start;
      load_pe(0, 32'h11, 32'h12, 32'h13, 1'b0);
      feed(32'h21, 1'b0);
      abort   = 1'b1;
      bs_v    = 1'b1;
      bs_data = 32'h22;
      tick;
      abort = 1'b0;
      chk1("abort_busy", busy, 1'b0);
      chk1("abort_bs_r", bs_r, 1'b0);
      chk1("abort_done", done, 1'b0);
      chk("abort_catch", 96'(catch_config), 96'(0));
      for (int i = 0; i < 4; i++) begin
         tick;
         chk("abort_quiet_catch", 96'(catch_config), 96'(0));
         chk1("abort_quiet_done", done, 1'b0);
      end
      do_start;
      load_pe(0, 32'h31, 32'h32, 32'h33, 1'b0);
      load_pe(1, 32'h34, 32'h35, 32'h36, 1'b0);
      finish_load(32'h31 ^ 32'h32 ^ 32'h33 ^ 32'h34 ^ 32'h35 ^ 32'h36, 1'b0);

      // asynchronous reset mid-load
      do_start;
      feed(32'hA1, 1'b0);
      feed(32'hA2, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_cfg", config_bits, 96'(0));
      chk1("midrst_bs_r", bs_r, 1'b0);
      chk1("midrst_busy", busy, 1'b0);
      tick;
      chk("midrst_catch", 96'(catch_config), 96'(0));
      rst_n = 1'b1;
      tick;
      chk("postrst_catch", 96'(catch_config), 96'(0));
      chk1("postrst_busy", busy, 1'b0);
      do_start;
      load_pe(0, 32'hB1, 32'hB2, 32'hB3, 1'b0);
      load_pe(1, 32'hB4, 32'hB5, 32'hB6, 1'b0);
      finish_load(32'hB1 ^ 32'hB2 ^ 32'hB3 ^ 32'hB4 ^ 32'hB5 ^ 32'hB6, 1'b0);

      // start during LOAD is ignored
      do_start;
      feed(32'h41, 1'b0);
      start = 1'b1;
      bs_v  = 1'b0;
      tick;
      start = 1'b0;
      chk1("restart_bs_r", bs_r, 1'b1);
      chk1("restart_busy", busy, 1'b1);
      feed(32'h42, 1'b0);
      feed(32'h43, 1'b0);
      chk("restart_catch", 96'(catch_config), 96'(1));
      chk("restart_cfg", config_bits, {32'h43, 32'h42, 32'h41});
      abort = 1'b1;
      tick;
      abort = 1'b0;
      chk1("commit_abort_busy", busy, 1'b0);
      tick;
      chk("commit_abort_catch", 96'(catch_config), 96'(0));

      // start together with abort in IDLE
      start = 1'b1;
      abort = 1'b1;
      tick;
      start = 1'b0;
      abort = 1'b0;
      chk1("start_abort_busy", busy, 1'b0);
      chk1("start_abort_bs_r", bs_r, 1'b0);

`ifdef CGRA_CFG_CHECKSUM_EN
      // wrong checksum sets err until the next start
      do_start;
      load_pe(0, 32'h1, 32'h2, 32'h3, 1'b0);
      load_pe(1, 32'h4, 32'h5, 32'h6, 1'b0);
      finish_load(32'h2, 1'b1);
      do_start;
      chk1("err_cleared", err, 1'b0);
      abort = 1'b1;
      tick;
      abort = 1'b0;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
